// File: rtl/fmul_pkg.sv
// Shared types for the FMUL32 operand-issue path.
//   OPC_W / RMODE_W : FMUL32 opcode and rounding-mode widths
//   seq_state_t     : issue sequencer states
//   fmul_req_t      : request payload at the default DATA_W/TAG_W
package fmul_pkg;

   localparam int unsigned OPC_W      = 2;
   localparam int unsigned RMODE_W    = 2;
   localparam int unsigned DEF_DATA_W = 32;
   localparam int unsigned DEF_TAG_W  = 4;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ISSUE = 2'd1,
      HOLD  = 2'd2
   } seq_state_t;

   typedef struct packed {
      logic [DEF_DATA_W-1:0] op1;
      logic [DEF_DATA_W-1:0] op2;
      logic [OPC_W-1:0]      opc;
      logic [RMODE_W-1:0]    rmode;
      logic [DEF_TAG_W-1:0]  tag;
   } fmul_req_t;

endpackage

// File: rtl/fmul_op_sequencer_fifo.sv
// Synchronous request FIFO for the operand sequencer.
//   clk, rst            : clock, synchronous active-high reset
//   push, push_data     : write an entry (ignored when full)
//   pop, pop_data       : read the head entry (pop ignored when empty; pop_data is the head)
//   count, full, empty  : occupancy from registered state
module fmul_req_fifo
   import fmul_pkg::*;
#(
   parameter type         entry_t = fmul_req_t,
   parameter int unsigned DEPTH   = 4
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     push,
   input  entry_t                   push_data,
   input  logic                     pop,
   output entry_t                   pop_data,
   output logic [$clog2(DEPTH):0]   count,
   output logic                     full,
   output logic                     empty
);

   localparam int unsigned PTR_W = $clog2(DEPTH);
   localparam int unsigned CNT_W = PTR_W + 1;

   entry_t           mem [DEPTH];
   logic [PTR_W-1:0] wr_ptr;
   logic [PTR_W-1:0] rd_ptr;
   logic [CNT_W-1:0] count_q;
   logic             push_ok;
   logic             pop_ok;

   assign full     = (count_q == CNT_W'(DEPTH));
   assign empty    = (count_q == '0);
   assign push_ok  = push && !full;
   assign pop_ok   = pop && !empty;
   assign count    = count_q;
   assign pop_data = mem[rd_ptr];

   // Pointers wrap naturally because DEPTH is a power of two.
   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr  <= '0;
         rd_ptr  <= '0;
         count_q <= '0;
      end else begin
         if (push_ok) wr_ptr <= wr_ptr + PTR_W'(1);
         if (pop_ok)  rd_ptr <= rd_ptr + PTR_W'(1);
         case ({push_ok, pop_ok})
            2'b10:   count_q <= count_q + CNT_W'(1);
            2'b01:   count_q <= count_q - CNT_W'(1);
            default: count_q <= count_q;
         endcase
      end
   end

   // Storage is not reset; only the pointers define validity.
   always_ff @(posedge clk) begin
      if (push_ok) mem[wr_ptr] <= push_data;
   end

endmodule

// File: rtl/fmul_op_sequencer.sv
// Operand-issue stage in front of FMUL32: queues requests, issues one at a time,
// holds operands for MUL_LAT cycles, then returns result/val/tag under valid/ready.
//   in_*       : request channel (valid/ready) with operands, opcode, rounding mode, tag
//   mul_*      : registered operands to FMUL32; mul_result/mul_val come back from it
//   out_*      : completion channel (valid/ready) with captured result, val and tag
//   fifo_count : queued entries; busy : work queued or in flight
module fmul_op_sequencer
   import fmul_pkg::*;
#(
   parameter int unsigned DATA_W  = DEF_DATA_W,
   parameter int unsigned DEPTH   = 4,
   parameter int unsigned TAG_W   = DEF_TAG_W,
   parameter int unsigned MUL_LAT = 1
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   in_valid,
   output logic                   in_ready,
   input  logic [DATA_W-1:0]      in_op1,
   input  logic [DATA_W-1:0]      in_op2,
   input  logic [OPC_W-1:0]       in_opc,
   input  logic [RMODE_W-1:0]     in_rmode,
   input  logic [TAG_W-1:0]       in_tag,
   output logic [DATA_W-1:0]      mul_op1,
   output logic [DATA_W-1:0]      mul_op2,
   output logic [OPC_W-1:0]       mul_opc,
   output logic [RMODE_W-1:0]     mul_rmode,
   input  logic [DATA_W-1:0]      mul_result,
   input  logic                   mul_val,
   output logic                   out_valid,
   input  logic                   out_ready,
   output logic [DATA_W-1:0]      out_result,
   output logic                   out_val,
   output logic [TAG_W-1:0]       out_tag,
   output logic [$clog2(DEPTH):0] fifo_count,
   output logic                   busy
);

   localparam int unsigned LAT_W = $clog2(MUL_LAT + 1);

   typedef struct packed {
      logic [DATA_W-1:0]  op1;
      logic [DATA_W-1:0]  op2;
      logic [OPC_W-1:0]   opc;
      logic [RMODE_W-1:0] rmode;
      logic [TAG_W-1:0]   tag;
   } req_t;

   seq_state_t       state_q;
   seq_state_t       state_d;
   logic [LAT_W-1:0] lat_q;
   logic [LAT_W-1:0] lat_d;
   logic             pop;
   logic             capture;
   logic             push;
   logic             full;
   logic             empty;
   req_t             push_req;
   req_t             head;
   logic [TAG_W-1:0] cur_tag;

   assign push     = in_valid && in_ready;
   assign push_req = '{op1: in_op1, op2: in_op2, opc: in_opc, rmode: in_rmode, tag: in_tag};

   fmul_req_fifo #(
      .entry_t (req_t),
      .DEPTH   (DEPTH)
   ) u_fifo (
      .clk       (clk),
      .rst       (rst),
      .push      (push),
      .push_data (push_req),
      .pop       (pop),
      .pop_data  (head),
      .count     (fifo_count),
      .full      (full),
      .empty     (empty)
   );

   // State register
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         lat_q   <= '0;
      end else begin
         state_q <= state_d;
         lat_q   <= lat_d;
      end
   end

   // Next-state: pop on IDLE or on a completed handshake so issue is back-to-back
   always_comb begin
      state_d = state_q;
      lat_d   = lat_q;
      pop     = 1'b0;
      capture = 1'b0;
      case (state_q)
         IDLE: begin
            if (!empty) begin
               pop     = 1'b1;
               state_d = ISSUE;
               lat_d   = LAT_W'(MUL_LAT);
            end
         end
         ISSUE: begin
            if (lat_q == '0) begin
               capture = 1'b1;
               state_d = HOLD;
            end else begin
               lat_d = lat_q - LAT_W'(1);
            end
         end
         HOLD: begin
            if (out_ready) begin
               if (!empty) begin
                  pop     = 1'b1;
                  state_d = ISSUE;
                  lat_d   = LAT_W'(MUL_LAT);
               end else begin
                  state_d = IDLE;
               end
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // Outputs decoded from registered state and occupancy
   always_comb begin
      out_valid = (state_q == HOLD);
      busy      = (state_q != IDLE) || !empty;
      in_ready  = !full;
   end

   // Operand and completion capture registers; mul_* keep the last issue
   always_ff @(posedge clk) begin
      if (rst) begin
         mul_op1    <= '0;
         mul_op2    <= '0;
         mul_opc    <= '0;
         mul_rmode  <= '0;
         cur_tag    <= '0;
         out_result <= '0;
         out_val    <= 1'b0;
         out_tag    <= '0;
      end else begin
         if (pop) begin
            mul_op1   <= head.op1;
            mul_op2   <= head.op2;
            mul_opc   <= head.opc;
            mul_rmode <= head.rmode;
            cur_tag   <= head.tag;
         end
         if (capture) begin
            out_result <= mul_result;
            out_val    <= mul_val;
            out_tag    <= cur_tag;
         end
      end
   end

endmodule

// File: tb/tb_fmul_op_sequencer.sv
// Scoreboard bench for fmul_op_sequencer with a one-cycle FMUL32 stand-in.
module tb_fmul_op_sequencer;
   import fmul_pkg::*;

   localparam int unsigned DATA_W  = 32;
   localparam int unsigned DEPTH   = 4;
   localparam int unsigned TAG_W   = 4;
   localparam int unsigned MUL_LAT = 1;

   logic                   clk;
   logic                   rst;
   logic                   in_valid;
   logic                   in_ready;
   logic [DATA_W-1:0]      in_op1;
   logic [DATA_W-1:0]      in_op2;
   logic [OPC_W-1:0]       in_opc;
   logic [RMODE_W-1:0]     in_rmode;
   logic [TAG_W-1:0]       in_tag;
   logic [DATA_W-1:0]      mul_op1;
   logic [DATA_W-1:0]      mul_op2;
   logic [OPC_W-1:0]       mul_opc;
   logic [RMODE_W-1:0]     mul_rmode;
   logic [DATA_W-1:0]      mul_result;
   logic                   mul_val;
   logic                   out_valid;
   logic                   out_ready;
   logic [DATA_W-1:0]      out_result;
   logic                   out_val;
   logic [TAG_W-1:0]       out_tag;
   logic [$clog2(DEPTH):0] fifo_count;
   logic                   busy;

   typedef struct {
      logic [31:0] result;
      logic        val;
      logic [3:0]  tag;
   } exp_t;

   exp_t sb[$];
   int   checks   = 0;
   int   failures = 0;

   // Directed table: exact products so truncation in the stand-in is exact
   logic [31:0] tbl_a   [6] = '{32'h40400000, 32'hbf800000, 32'h3f000000, 32'h40000000, 32'h3fc00000, 32'h41200000};
   logic [31:0] tbl_b   [6] = '{32'h40400000, 32'h40a00000, 32'h3f000000, 32'hc0000000, 32'h3fc00000, 32'h41200000};
   logic [31:0] tbl_r   [6] = '{32'h41100000, 32'hc0a00000, 32'h3e800000, 32'hc0800000, 32'h40100000, 32'h42c80000};
   logic [1:0]  tbl_opc [6] = '{2'd0, 2'd0, 2'd0, 2'd3, 2'd0, 2'd0};

   fmul_op_sequencer #(
      .DATA_W  (DATA_W),
      .DEPTH   (DEPTH),
      .TAG_W   (TAG_W),
      .MUL_LAT (MUL_LAT)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .in_valid   (in_valid),
      .in_ready   (in_ready),
      .in_op1     (in_op1),
      .in_op2     (in_op2),
      .in_opc     (in_opc),
      .in_rmode   (in_rmode),
      .in_tag     (in_tag),
      .mul_op1    (mul_op1),
      .mul_op2    (mul_op2),
      .mul_opc    (mul_opc),
      .mul_rmode  (mul_rmode),
      .mul_result (mul_result),
      .mul_val    (mul_val),
      .out_valid  (out_valid),
      .out_ready  (out_ready),
      .out_result (out_result),
      .out_val    (out_val),
      .out_tag    (out_tag),
      .fifo_count (fifo_count),
      .busy       (busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Normal-number single-precision multiply, truncating
   function automatic logic [31:0] fmul_model(input logic [31:0] a, input logic [31:0] b);
      logic [47:0] p;
      logic [9:0]  e;
      logic [22:0] m;
      if (a[30:23] == 8'd0 || b[30:23] == 8'd0) return {a[31] ^ b[31], 31'd0};
      p = {1'b1, a[22:0]} * {1'b1, b[22:0]};
      e = 10'(a[30:23]) + 10'(b[30:23]) - 10'd127;
      if (p[47]) begin
         e = e + 10'd1;
         m = p[46:24];
      end else begin
         m = p[45:23];
      end
      return {a[31] ^ b[31], e[7:0], m};
   endfunction

   // Small positive integer to single precision
   function automatic logic [31:0] int_to_f32(input int unsigned n);
      int          msb;
      logic [31:0] nn;
      logic [22:0] mant;
      msb = 0;
      nn  = n;
      for (int i = 0; i < 32; i++) if (nn[i]) msb = i;
      mant = 23'(nn << (23 - msb));
      return {1'b0, 8'(127 + msb), mant};
   endfunction

   // FMUL32 stand-in: result one cycle after operands; opcode 3 reports val=0
   always @(posedge clk) begin
      if (rst) begin
         mul_result <= '0;
         mul_val    <= 1'b0;
      end else begin
         mul_result <= fmul_model(mul_op1, mul_op2);
         mul_val    <= (mul_opc != 2'b11);
      end
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // Monitor: compare every presented output against the scoreboard head
   always @(negedge clk) begin
      if (!rst && out_valid) begin
         if (sb.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL unexpected_out: got tag %h expected no output", out_tag);
         end else begin
            chk("out_result", out_result, sb[0].result);
            chk("out_val", 32'(out_val), 32'(sb[0].val));
            chk("out_tag", 32'(out_tag), 32'(sb[0].tag));
            if (out_ready) void'(sb.pop_front());
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Present a request and hold it until accepted; expected result queued on acceptance
   task automatic push_req(input logic [31:0] a, input logic [31:0] b, input logic [1:0] opc,
                           input logic [3:0] tag, input logic [31:0] exp_res, input logic exp_val,
                           input bit rand_ready);
      bit done;
      done     = 1'b0;
      in_op1   = a;
      in_op2   = b;
      in_opc   = opc;
      in_rmode = 2'($urandom_range(0, 3));
      in_tag   = tag;
      in_valid = 1'b1;
      for (int i = 0; i < 200 && !done; i++) begin
         if (rand_ready) out_ready = ($urandom_range(0, 3) != 0);
         done = in_ready;
         if (done) sb.push_back('{exp_res, exp_val, tag});
         tick();
      end
      if (!done) begin
         checks++;
         failures++;
         $display("FAIL push_timeout: got in_ready=0 for 200 cycles expected acceptance");
      end
   endtask

   task automatic wait_idle();
      int n;
      n = 0;
      while (busy && n < 500) begin
         tick();
         n++;
      end
      chk("drain_busy", 32'(busy), 32'd0);
   endtask

   initial begin
      rst       = 1'b1;
      in_valid  = 1'b0;
      in_op1    = '0;
      in_op2    = '0;
      in_opc    = '0;
      in_rmode  = '0;
      in_tag    = '0;
      out_ready = 1'b0;
      tick();
      tick();
      rst = 1'b0;

      // Reset state
      chk("rst_count", 32'(fifo_count), 32'd0);
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_out_valid", 32'(out_valid), 32'd0);
      chk("rst_in_ready", 32'(in_ready), 32'd1);
      chk("rst_mul_op1", mul_op1, 32'd0);
      chk("rst_out_result", out_result, 32'd0);

      // Single request latency: 1.5 x 2.0 = 3.0, out_valid in push cycle + 4
      out_ready = 1'b1;
      push_req(32'h3fc00000, 32'h40000000, 2'd0, 4'd5, 32'h40400000, 1'b1, 1'b0);
      in_valid = 1'b0;
      chk("lat_t1_valid", 32'(out_valid), 32'd0);
      tick();
      chk("lat_t2_valid", 32'(out_valid), 32'd0);
      chk("lat_t2_mul_op1", mul_op1, 32'h3fc00000);
      chk("lat_t2_mul_op2", mul_op2, 32'h40000000);
      tick();
      chk("lat_t3_valid", 32'(out_valid), 32'd0);
      tick();
      chk("lat_t4_valid", 32'(out_valid), 32'd1);
      wait_idle();
      chk("retain_mul_op1", mul_op1, 32'h3fc00000);

      // Fill with consumer stalled: five accepted (first pops), FIFO then full
      out_ready = 1'b0;
      for (int k = 0; k < 5; k++)
         push_req(tbl_a[k], tbl_b[k], tbl_opc[k], 4'(k), tbl_r[k], tbl_opc[k] != 2'd3, 1'b0);
      in_valid = 1'b0;
      chk("full_count", 32'(fifo_count), 32'd4);
      chk("full_in_ready", 32'(in_ready), 32'd0);
      chk("full_out_valid", 32'(out_valid), 32'd1);

      // Long HOLD stall: nothing new issues, operands stay put
      for (int c = 0; c < 10; c++) begin
         tick();
         chk("stall_valid", 32'(out_valid), 32'd1);
         chk("stall_count", 32'(fifo_count), 32'd4);
         chk("stall_mul_op1", mul_op1, tbl_a[0]);
         chk("stall_mul_opc", 32'(mul_opc), 32'(tbl_opc[0]));
      end

      // Release while pushing into a full FIFO: push rejected, next issued same edge
      in_op1    = tbl_a[5];
      in_op2    = tbl_b[5];
      in_opc    = tbl_opc[5];
      in_tag    = 4'd5;
      in_valid  = 1'b1;
      out_ready = 1'b1;
      chk("fullpush_in_ready", 32'(in_ready), 32'd0);
      tick();
      chk("release_count", 32'(fifo_count), 32'd3);
      chk("release_out_valid", 32'(out_valid), 32'd0);
      chk("release_mul_op1", mul_op1, tbl_a[1]);
      chk("release_in_ready", 32'(in_ready), 32'd1);
      sb.push_back('{tbl_r[5], 1'b1, 4'd5});
      tick();
      in_valid = 1'b0;
      chk("refill_count", 32'(fifo_count), 32'd4);
      wait_idle();

      // Reset during ISSUE with three queued discards everything
      out_ready = 1'b1;
      for (int k = 0; k < 5; k++)
         push_req(tbl_a[k], tbl_b[k], tbl_opc[k], 4'(k + 8), tbl_r[k], tbl_opc[k] != 2'd3, 1'b0);
      in_valid = 1'b0;
      chk("pre_rst_out_valid", 32'(out_valid), 32'd0);
      chk("pre_rst_count", 32'(fifo_count), 32'd3);
      chk("pre_rst_busy", 32'(busy), 32'd1);
      rst = 1'b1;
      sb.delete();
      tick();
      rst = 1'b0;
      chk("mid_rst_count", 32'(fifo_count), 32'd0);
      chk("mid_rst_out_valid", 32'(out_valid), 32'd0);
      chk("mid_rst_busy", 32'(busy), 32'd0);
      chk("mid_rst_in_ready", 32'(in_ready), 32'd1);
      chk("mid_rst_mul_op1", mul_op1, 32'd0);
      chk("mid_rst_out_tag", 32'(out_tag), 32'd0);
      for (int c = 0; c < 10; c++) begin
         tick();
         chk("post_rst_quiet", 32'(out_valid), 32'd0);
      end

      // Small-integer products with random consumer stalls
      for (int k = 0; k < 40; k++) begin
         int unsigned x;
         int unsigned y;
         x = $urandom_range(1, 15);
         y = $urandom_range(1, 15);
         push_req(int_to_f32(x), int_to_f32(y), 2'd0, 4'(k), int_to_f32(x * y), 1'b1, 1'b1);
      end
      in_valid  = 1'b0;
      out_ready = 1'b1;
      wait_idle();
      tick();
      chk("sb_drained", 32'(sb.size()), 32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got no completion expected finish before 200000");
      $fatal(1, "watchdog");
   end

endmodule
